// File: rtl/fb_write_ctrl.sv
// Frame-buffer port-A write controller: solid-colour fill or streamed load of
// one H_RES x V_RES RGB444 frame, one pixel per cycle, with abort and done pulse.
module fb_write_ctrl #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fill_start,
    input  logic [11:0] fill_color,
    input  logic        load_start,
    input  logic        abort,
    input  logic        pix_valid,
    input  logic [11:0] pix_data,
    output logic        pix_ready,
    output logic        wea,
    output logic [16:0] addra,
    output logic [11:0] dina,
    output logic        busy,
    output logic        done
);
    localparam int          NPIX = H_RES * V_RES;
    localparam logic [16:0] LAST = 17'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [16:0] r_cnt;
    logic [11:0] r_color;
    logic        r_wea;
    logic [16:0] r_addra;
    logic [11:0] r_dina;
    logic        w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (fill_start)      w_next = FILL;
                else if (load_start) w_next = LOAD;
            end
            FILL: begin
                if (abort)       w_next = IDLE;
                else if (w_last) w_next = DONE;
            end
            LOAD: begin
                if (abort)                    w_next = IDLE;
                else if (pix_valid && w_last) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        pix_ready = (r_state == LOAD);
    end

    // Write port is registered; cnt stops at LAST so it never wraps past the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_color <= '0;
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
        end else begin
            r_wea <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (fill_start) begin
                        r_color <= fill_color;
                        r_cnt   <= '0;
                    end else if (load_start) begin
                        r_cnt <= '0;
                    end
                end
                FILL: begin
                    if (abort) begin
                        r_cnt <= '0;
                    end else begin
                        r_wea   <= 1'b1;
                        r_addra <= r_cnt;
                        r_dina  <= r_color;
                        if (!w_last) r_cnt <= r_cnt + 17'd1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        r_cnt <= '0;
                    end else if (pix_valid) begin
                        r_wea   <= 1'b1;
                        r_addra <= r_cnt;
                        r_dina  <= pix_data;
                        if (!w_last) r_cnt <= r_cnt + 17'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wea   = r_wea;
    assign addra = r_addra;
    assign dina  = r_dina;
endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench: a 4x2 instance driven from a vector table plus hand sequences,
// and a default-size instance fed one full 320x240 streamed load.
module tb_fb_write_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small 4x2 instance
    logic        rst, fs, ls, ab, pv;
    logic [11:0] fc, pd;
    logic        rdy, wea, busy, done;
    logic [16:0] addra;
    logic [11:0] dina;

    fb_write_ctrl #(.H_RES(4), .V_RES(2)) u_small (
        .clk(clk), .rst(rst), .fill_start(fs), .fill_color(fc), .load_start(ls),
        .abort(ab), .pix_valid(pv), .pix_data(pd), .pix_ready(rdy), .wea(wea),
        .addra(addra), .dina(dina), .busy(busy), .done(done));

    // default-size instance
    logic        b_rst, b_fs, b_ls, b_ab, b_pv;
    logic [11:0] b_fc, b_pd;
    logic        b_rdy, b_wea, b_busy, b_done;
    logic [16:0] b_addra;
    logic [11:0] b_dina;

    fb_write_ctrl u_big (
        .clk(clk), .rst(b_rst), .fill_start(b_fs), .fill_color(b_fc), .load_start(b_ls),
        .abort(b_ab), .pix_valid(b_pv), .pix_data(b_pd), .pix_ready(b_rdy), .wea(b_wea),
        .addra(b_addra), .dina(b_dina), .busy(b_busy), .done(b_done));

    typedef struct {
        logic        fs;
        logic [11:0] fc;
        logic        ls, ab, pv;
        logic [11:0] pd;
        logic        wea;
        logic [16:0] addra;
        logic [11:0] dina;
        logic        busy, done, rdy;
    } vec_t;

    vec_t vt[64];
    int   nv = 0;
    int   nchecks = 0;
    int   nerr = 0;

    task automatic add(input logic f, input logic [11:0] c, input logic l, input logic a,
                       input logic v, input logic [11:0] d, input logic ew,
                       input logic [16:0] ea, input logic [11:0] ed, input logic eb,
                       input logic edn, input logic er);
        vt[nv] = '{f, c, l, a, v, d, ew, ea, ed, eb, edn, er};
        nv++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ew, input logic [16:0] ea,
                              input logic [11:0] ed, input logic eb, input logic edn,
                              input logic er);
        check({tag, " wea"}, 32'(wea), 32'(ew));
        check({tag, " addra"}, 32'(addra), 32'(ea));
        check({tag, " dina"}, 32'(dina), 32'(ed));
        check({tag, " busy"}, 32'(busy), 32'(eb));
        check({tag, " done"}, 32'(done), 32'(edn));
        check({tag, " pix_ready"}, 32'(rdy), 32'(er));
    endtask

    task automatic drive(input logic f, input logic [11:0] c, input logic l,
                         input logic a, input logic v, input logic [11:0] d);
        @(negedge clk);
        fs = f; fc = c; ls = l; ab = a; pv = v; pd = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nwr, ndone, oob, seqerr;
        logic [16:0] last_a, done_a, exp_a;
        logic done_wea;

        // fill with simultaneous load_start (fill wins), load_start mid-fill ignored
        add(1, 12'hF00, 1, 0, 0, 12'h0, 0, 17'd0, 12'h000, 1, 0, 0);
        for (int k = 0; k < 7; k++)
            add(0, 12'h0, (k == 1 || k == 4), 0, 0, 12'h0, 1, 17'(k), 12'hF00, 1, 0, 0);
        add(0, 12'h0, 0, 0, 0, 12'h0, 1, 17'd7, 12'hF00, 1, 1, 0);
        add(0, 12'h0, 0, 1, 0, 12'h0, 0, 17'd7, 12'hF00, 0, 0, 0);
        // throttled load, pix_valid 1,0,1,0...
        add(0, 12'h0, 1, 0, 0, 12'h0, 0, 17'd7, 12'hF00, 1, 0, 1);
        for (int i = 0; i < 8; i++) begin
            add(0, 12'h0, 0, 0, 1, 12'(i + 1), 1, 17'(i), 12'(i + 1), 1, (i == 7), (i != 7));
            if (i != 7)
                add(0, 12'h0, 0, 0, 0, 12'hEEE, 0, 17'(i), 12'(i + 1), 1, 0, 1);
        end
        add(0, 12'h0, 0, 0, 0, 12'h0, 0, 17'd7, 12'h008, 0, 0, 0);
        // abort at cnt=3 in LOAD with pix_valid=1, then a new fill from addr 0
        add(0, 12'h0, 1, 0, 0, 12'h0, 0, 17'd7, 12'h008, 1, 0, 1);
        for (int i = 0; i < 3; i++)
            add(0, 12'h0, 0, 0, 1, 12'(12'hA0 + i), 1, 17'(i), 12'(12'hA0 + i), 1, 0, 1);
        add(0, 12'h0, 0, 1, 1, 12'h0AF, 0, 17'd2, 12'h0A2, 0, 0, 0);
        add(1, 12'h0AB, 0, 0, 0, 12'h0, 0, 17'd2, 12'h0A2, 1, 0, 0);
        add(0, 12'h0, 0, 0, 0, 12'h0, 1, 17'd0, 12'h0AB, 1, 0, 0);
        add(0, 12'h0, 0, 1, 0, 12'h0, 0, 17'd0, 12'h0AB, 0, 0, 0);
        // idle: abort and a stray pix_valid do nothing
        add(0, 12'h0, 0, 1, 1, 12'h555, 0, 17'd0, 12'h0AB, 0, 0, 0);

        fs = 0; fc = '0; ls = 0; ab = 0; pv = 0; pd = '0;
        b_fs = 0; b_fc = '0; b_ls = 0; b_ab = 0; b_pv = 0; b_pd = '0;
        rst = 1; b_rst = 1;
        #1;
        check_outs("reset", 0, 17'd0, 12'h000, 0, 0, 0);
        @(negedge clk);
        rst = 0; b_rst = 0;

        for (int n = 0; n < nv; n++) begin
            drive(vt[n].fs, vt[n].fc, vt[n].ls, vt[n].ab, vt[n].pv, vt[n].pd);
            check_outs($sformatf("vec%0d", n), vt[n].wea, vt[n].addra, vt[n].dina,
                       vt[n].busy, vt[n].done, vt[n].rdy);
        end

        // async reset between edges mid-fill
        drive(1, 12'h123, 0, 0, 0, 12'h0);
        drive(0, 12'h0, 0, 0, 0, 12'h0);
        drive(0, 12'h0, 0, 0, 0, 12'h0);
        check_outs("prerst", 1, 17'd1, 12'h123, 1, 0, 0);
        @(negedge clk);
        #2 rst = 1;
        #1;
        check_outs("asyncrst", 0, 17'd0, 12'h000, 0, 0, 0);
        @(posedge clk);
        #1;
        check_outs("rsthold", 0, 17'd0, 12'h000, 0, 0, 0);
        @(negedge clk);
        rst = 0;
        fs = 1; fc = 12'h0F0;
        @(posedge clk);
        #1;
        check_outs("firststart", 0, 17'd0, 12'h000, 1, 0, 0);
        drive(0, 12'h0, 0, 0, 0, 12'h0);
        check_outs("postrstfill", 1, 17'd0, 12'h0F0, 1, 0, 0);
        drive(0, 12'h0, 0, 1, 0, 12'h0);

        // full default-size streamed load
        @(negedge clk);
        b_ls = 1;
        @(posedge clk);
        #1;
        check("big start busy", 32'(b_busy), 32'd1);
        nwr = 0; ndone = 0; oob = 0; seqerr = 0;
        last_a = '0; done_a = '0; exp_a = '0; done_wea = 0;
        for (int k = 0; k < 76900; k++) begin
            @(negedge clk);
            b_ls = 0; b_pv = 1; b_pd = 12'(k);
            @(posedge clk);
            #1;
            if (b_wea) begin
                nwr++;
                if (b_addra >= 17'd76800) oob++;
                if (b_addra != exp_a || b_dina != b_addra[11:0]) seqerr++;
                exp_a  = exp_a + 17'd1;
                last_a = b_addra;
            end
            if (b_done) begin
                ndone++;
                done_a   = b_addra;
                done_wea = b_wea;
            end
            if (!b_busy) break;
        end
        @(negedge clk);
        b_pv = 0;
        @(posedge clk);
        #1;
        check("big idle wea", 32'(b_wea), 32'd0);
        check("big writes", 32'(nwr), 32'd76800);
        check("big last addra", 32'(last_a), 32'd76799);
        check("big done count", 32'(ndone), 32'd1);
        check("big done addra", 32'(done_a), 32'd76799);
        check("big done with wea", 32'(done_wea), 32'd1);
        check("big out of range", 32'(oob), 32'd0);
        check("big sequence errs", 32'(seqerr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/fb_write_ctrl.md
FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- H_RES, default 320, horizontal pixels.
- V_RES, default 240, vertical pixels.
- NPIX = H_RES*V_RES (76800), derived; not overridable.

REQ-002 The block SHALL have these ports, as name, direction, width, meaning:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- fill_start  in  1  one-cycle request to fill the whole frame with fill_color.
- fill_color  in  12  RGB444 fill value; sampled on the accepted fill_start cycle.
- load_start  in  1  one-cycle request to load a frame from the SD pixel stream.
- abort  in  1  terminate current operation.
- pix_valid  in  1  SD stream pixel valid.
- pix_data  in  12  SD stream pixel, RGB444.
- pix_ready  out  1  controller accepts the stream pixel.
- wea  out  1  frame-buffer port-A write enable.
- addra  out  17  frame-buffer port-A address.
- dina  out  12  frame-buffer port-A write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 The state machine SHALL have four states, encoded IDLE=0, FILL=1, LOAD=2, DONE=3.
REQ-004 In IDLE, fill_start=1 SHALL go to FILL; otherwise load_start=1 SHALL go to LOAD.
- Fill has priority when both are asserted.
- Entry clears the pixel counter cnt to 0.
- fill_start also latches fill_color.
REQ-005 fill_start and load_start SHALL be ignored in every state except IDLE.
REQ-006 In FILL, each cycle with cnt=k SHALL register wea=1, addra=k, dina=latched color at the next edge, then increment cnt.
REQ-007 In FILL, when cnt=NPIX-1 the block SHALL issue that final write and enter DONE on the same edge.
REQ-008 pix_ready SHALL be combinational and equal to (state==LOAD); it SHALL be 0 in all other states.
REQ-009 In LOAD, each cycle with pix_valid=1 SHALL register wea=1, addra=cnt, dina=pix_data at the next edge, then increment cnt.
REQ-010 In LOAD, a cycle with pix_valid=0 SHALL register wea=0 and hold cnt.
REQ-011 In LOAD, acceptance at cnt=NPIX-1 SHALL write that pixel and enter DONE on the same edge.
REQ-012 Write latency SHALL be exactly 1 cycle from the accepting or issuing cycle to wea=1 on the outputs.
REQ-013 No write SHALL occur at an address ≥ NPIX, and cnt SHALL never wrap.
REQ-014 done SHALL equal (state==DONE), i.e. high for exactly one cycle, coincident with the final wea cycle; DONE SHALL always go to IDLE.
REQ-015 busy SHALL equal (state!=IDLE).
REQ-016 abort=1 in FILL or LOAD SHALL force IDLE at the next edge.
- No done pulse.
- A pixel accepted in the same cycle is not written (wea=0 next cycle).
- cnt is cleared.
REQ-017 abort SHALL be ignored in IDLE and DONE.
REQ-018 When wea=0, addra and dina SHALL hold their last values.

Reset
REQ-019 rst=1 SHALL immediately, without a clock edge, force:
- state=IDLE, cnt=0.
- wea=0, addra=0, dina=0.
- done=0, busy=0, pix_ready=0.
- latched color=0.
REQ-020 Reset asserted mid-FILL or mid-LOAD SHALL abandon the operation; no further writes occur.
REQ-021 After rst deasserts, the block SHALL accept a start on the first clock edge.

Verification
REQ-022 Fill: H_RES=4, V_RES=2; pulse fill_start with fill_color=12'hF00 -> wea high 8 consecutive cycles, addra 0..7, dina=F00, done on the addra=7 cycle, then busy=0.
REQ-023 Throttled load: NPIX=8; pix_valid toggled 1,0,1,... with data 12'h001..12'h008 -> 8 writes at addra 0..7 with matching data, gaps aligned to the pix_valid=0 cycles, one done pulse.
REQ-024 Priority and ignore: fill_start and load_start in the same IDLE cycle -> FILL; load_start pulsed mid-FILL -> ignored, pix_ready stays 0.
REQ-025 Abort: abort at cnt=3 during LOAD with pix_valid=1 -> last write addra=2, no done, busy=0 next cycle; a new fill then starts at addra 0.
REQ-026 Async reset: rst asserted between clock edges mid-FILL -> wea and busy drop to 0 before the next edge; no write follows.
REQ-027 Default size: full 320x240 load -> final write addra=76799, done pulse; no address ≥ 76800 ever appears.
